ex_operand_stage: RTL and testbench

ID/EX pipeline register and EX-operand selector for the 5-stage 32-bit core. It registers decoded fields and forwards EX/MEM and MEM/WB results into the two ALU operands. It detects load-use hazards, inserting a bubble and holding the front end. It sits directly upstream of the ALU: `ex_a`, `ex_b` and `ex_alu_ctrl` drive the ALU's `a`, `b` and `alu_ctrl` inputs without further logic.

---
 rtl/ex_operand_stage.sv | 144 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ex_operand_stage: ID/EX register, EX operand forwarding mux and load-use bubble insertion.
// Revision 1.0
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [2:0]      id_alu_ctrl,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_bne,
  input  logic            flush,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [2:0]      ex_alu_ctrl,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_bne,
  output logic            load_use_stall
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [RA_W-1:0] rs1_q, rs1_d;
  logic [RA_W-1:0] rs2_q, rs2_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            alu_src_q, alu_src_d;
  logic [2:0]      alu_ctrl_q, alu_ctrl_d;
  logic [4:0]      ctl_q, ctl_d;  // {reg_write, mem_read, mem_write, branch, bne}

  logic            wt_rs1, wt_rs2;
  logic [XLEN-1:0] fwd_a, fwd_b;

  assign load_use_stall = valid_q & ctl_q[3] & (rd_q != '0) & id_valid &
                          ((rd_q == id_rs1) | (rd_q == id_rs2)) & ~flush;

  // Register file writes in the same cycle are not yet visible on id_rsN_data.
  assign wt_rs1 = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs1);
  assign wt_rs2 = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs2);

  always_comb begin
    valid_d    = id_valid;
    rs1_data_d = wt_rs1 ? wb_data : id_rs1_data;
    rs2_data_d = wt_rs2 ? wb_data : id_rs2_data;
    rs1_d      = id_rs1;
    rs2_d      = id_rs2;
    rd_d       = id_rd;
    imm_d      = id_imm;
    alu_src_d  = id_alu_src;
    alu_ctrl_d = id_alu_ctrl;
    ctl_d      = {id_reg_write, id_mem_read, id_mem_write, id_branch, id_bne} & {5{id_valid}};
    if (flush || load_use_stall) begin
      valid_d    = 1'b0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      imm_d      = '0;
      alu_src_d  = 1'b0;
      alu_ctrl_d = 3'b000;
      ctl_d      = 5'b00000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_src_q  <= 1'b0;
      alu_ctrl_q <= 3'b000;
      ctl_q      <= 5'b00000;
    end else begin
      valid_q    <= valid_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      alu_src_q  <= alu_src_d;
      alu_ctrl_q <= alu_ctrl_d;
      ctl_q      <= ctl_d;
    end
  end

  // EX/MEM is the younger result, so it takes priority over MEM/WB.
  always_comb begin
    fwd_a = rs1_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q))
      fwd_a = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q))
      fwd_a = wb_data;
    fwd_b = rs2_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q))
      fwd_b = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q))
      fwd_b = wb_data;
  end

  assign ex_valid      = valid_q;
  assign ex_a          = fwd_a;
  assign ex_b          = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctl_q[4];
  assign ex_mem_read   = ctl_q[3];
  assign ex_mem_write  = ctl_q[2];
  assign ex_branch     = ctl_q[1];
  assign ex_bne        = ctl_q[0];

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// tb_ex_operand_stage: scoreboard bench with an abstract pipeline-slot model.
// Revision 1.0
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_bne;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_bne;
  logic        load_use_stall;

  always #10 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_bne(id_bne),
    .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_bne(ex_bne),
    .load_use_stall(load_use_stall)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alu_src;
    logic [2:0]  ctrl;
    logic [4:0]  ctl;   // reg_write, mem_read, mem_write, branch, bne
  } slot_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b, sd;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    logic        stall;
  } exp_t;

  slot_t m;
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic  last_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
    if (rs == 0) return regval;
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd == rs) return wb_data;
    return regval;
  endfunction

  function automatic logic [31:0] wt(input logic [4:0] rs, input logic [31:0] d);
    return (wb_reg_write && wb_rd != 0 && wb_rd == rs) ? wb_data : d;
  endfunction

  function automatic logic model_stall();
    logic needs_load;
    needs_load = id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    return m.valid && m.ctl[3] && m.rd != 0 && needs_load && !flush;
  endfunction

  // Advance the model over one clock edge using the inputs present at that edge.
  task automatic tick();
    slot_t n;
    @(posedge clk);
    n = '0;
    if (!rst && !flush && !model_stall()) begin
      n.valid   = id_valid;
      n.rs1     = id_rs1;
      n.rs2     = id_rs2;
      n.rd      = id_rd;
      n.d1      = wt(id_rs1, id_rs1_data);
      n.d2      = wt(id_rs2, id_rs2_data);
      n.imm     = id_imm;
      n.alu_src = id_alu_src;
      n.ctrl    = id_alu_ctrl;
      n.ctl     = {id_reg_write, id_mem_read, id_mem_write, id_branch, id_bne} & {5{id_valid}};
    end
    m = n;
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.valid = m.valid;
    e.a     = fwd(m.rs1, m.d1);
    e.sd    = fwd(m.rs2, m.d2);
    e.b     = m.alu_src ? m.imm : e.sd;
    e.ctrl  = m.ctrl;
    e.rd    = m.rd;
    e.ctl   = m.ctl;
    e.stall = model_stall();
    last_stall = e.stall;
    exp_q.push_back(e);
  endtask

  task automatic idle_fwd();
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] ctl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = 32'h0; id_alu_src = 0; id_alu_ctrl = 3'b000;
    {id_reg_write, id_mem_read, id_mem_write, id_branch, id_bne} = ctl;
  endtask

  task automatic rand_id();
    set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
    id_imm = $urandom; id_alu_src = 1'($urandom); id_alu_ctrl = 3'($urandom_range(0, 3));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_a", ex_a, e.a);
        chk("ex_b", ex_b, e.b);
        chk("ex_store_data", ex_store_data, e.sd);
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(e.ctrl));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("ex_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_bne}), 32'(e.ctl));
        chk("load_use_stall", 32'(load_use_stall), 32'(e.stall));
      end
    end
  end

  initial begin : stim
    m = '0;
    rst = 1; flush = 0; idle_fwd(); rand_id();
    // Reset held two cycles with random decode traffic
    repeat (2) begin
      tick(); rand_id(); push_exp();
    end
    #2;
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset ex_a", ex_a, 0);
    chk("reset ex_b", ex_b, 0);
    chk("reset stall", 32'(load_use_stall), 0);

    // Plain capture
    tick(); rst = 0;
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'b10000); push_exp();
    tick(); set_id(1, 5'd3, 5'd5, 5'd8, 32'h99, 32'h44, 5'b10000); push_exp();
    #2;
    chk("cap ex_valid", 32'(ex_valid), 1);
    chk("cap ex_a", ex_a, 5);
    chk("cap ex_b", ex_b, 7);
    chk("cap ex_rd", 32'(ex_rd), 3);

    // Forwarding priority with ex_rs1=3
    tick(); exp_q.pop_back();
    set_id(1, 5'd0, 5'd0, 5'd9, 32'h77, 32'h0, 5'b10000);
    mem_reg_write = 1; mem_rd = 3; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 3; wb_data = 32'h22;
    #1 chk("fwd mem wins", ex_a, 32'h11);
    mem_reg_write = 0;
    #1 chk("fwd wb", ex_a, 32'h22);
    push_exp();
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 0; wb_data = 32'h22;
    push_exp();
    #1 chk("fwd x0", ex_a, 32'h77);

    // Load-use hazard
    tick(); idle_fwd(); set_id(1, 5'd1, 5'd2, 5'd4, 0, 0, 5'b11000); push_exp();
    tick(); set_id(1, 5'd1, 5'd4, 5'd7, 32'h1, 32'h2, 5'b10000); push_exp();
    #1 chk("lu stall", 32'(load_use_stall), 1);
    tick(); push_exp();
    #1 chk("lu bubble", 32'(ex_valid), 0);
    chk("lu stall off", 32'(load_use_stall), 0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0); push_exp();
    #1 chk("lu captured", 32'(ex_rd), 7);

    // Flush coinciding with a hazard
    tick(); set_id(1, 5'd1, 5'd2, 5'd4, 0, 0, 5'b11000); push_exp();
    tick(); set_id(1, 5'd4, 5'd2, 5'd7, 0, 0, 5'b10000); flush = 1; push_exp();
    #1 chk("flush stall", 32'(load_use_stall), 0);
    tick(); flush = 0; set_id(0, 0, 0, 0, 0, 0, 0); push_exp();
    #1 chk("flush bubble", 32'(ex_valid), 0);
    chk("flush reg_write", 32'(ex_reg_write), 0);

    // Immediate operand and capture-time write-through
    tick(); set_id(1, 5'd1, 5'd6, 5'd2, 32'h1, 32'h13, 5'b10000);
    id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
    wb_reg_write = 1; wb_rd = 6; wb_data = 32'h55; push_exp();
    tick(); idle_fwd(); set_id(0, 0, 0, 0, 0, 0, 0); push_exp();
    #1 chk("imm ex_b", ex_b, 32'hFFFF_FFFC);
    chk("wt store", ex_store_data, 32'h55);

    // Randomized traffic; the front end holds decode while stalled
    for (int i = 0; i < 400; i++) begin
      tick();
      rst   = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!last_stall) rand_id();
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_reg_write  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_data    = $urandom;
      push_exp();
    end
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
